// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared bus lengths and field bit indices for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int c_EXCEPT_LEN      = 2;
    // pc(32) + mul_op(3) + alu_result(32) + load_op(5) + dest(5) + gr_we(1)
    localparam int c_ES2MS_BUS_LEN   = 78 + c_EXCEPT_LEN;
    localparam int c_MS2WS_BUS_LEN   = 70 + c_EXCEPT_LEN;
    localparam int c_FORWARD_BUS_LEN = 38;

    localparam int c_LD_B  = 0;
    localparam int c_LD_H  = 1;
    localparam int c_LD_W  = 2;
    localparam int c_LD_BU = 3;
    localparam int c_LD_HU = 4;

    localparam int c_MUL_W    = 0;
    localparam int c_MULH_W   = 1;
    localparam int c_MULH_WU  = 2;

    localparam int c_EXC_BIT    = 0;
    localparam int c_CSR_RE_BIT = 1;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Load lane selection and sign/zero extension (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [4:0]  i_load_op,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_result = 32'b0;
        if (i_load_op[c_LD_B] | i_load_op[c_LD_BU]) begin
            o_result = ext8(w_byte, i_load_op[c_LD_B]);
        end else if (i_load_op[c_LD_H] | i_load_op[c_LD_HU]) begin
            o_result = ext16(w_half, i_load_op[c_LD_H]);
        end else if (i_load_op[c_LD_W]) begin
            o_result = i_rdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage: load extension, multiply result select,
//               one-cycle SRAM/multiplier capture across write-back stalls.
//               Optional macro MS_LOAD_FWD_EN forwards extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EXCEPT_LEN    = c_EXCEPT_LEN,
    parameter int ES2MS_BUS_LEN = 78 + EXCEPT_LEN,
    parameter int MS2WS_BUS_LEN = 70 + EXCEPT_LEN
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     es2ms_valid,
    output logic                     ms_allowin,
    input  logic [ES2MS_BUS_LEN-1:0] es2ms_bus,
    input  logic                     es_res_from_mul,
    input  logic                     ws_allowin,
    output logic                     ms2ws_valid,
    output logic [MS2WS_BUS_LEN-1:0] ms2ws_bus,
    input  logic [31:0]              data_sram_rdata,
    input  logic [67:0]              mul_result,
    output logic [37:0]              mem_forward_zip,
    output logic                     ms_ld_block,
    input  logic                     wb_ex,
    output logic                     ms_ex,
    output logic                     ms_csr_re
);

    logic                     r_ms_valid;
    logic                     r_first;
    logic                     r_res_from_mul;
    logic [ES2MS_BUS_LEN-1:0] r_es2ms_bus;
    logic [31:0]              r_rdata_buf;
    logic                     r_rdata_buf_v;
    logic [63:0]              r_mul_buf;
    logic                     r_mul_buf_v;

    logic [31:0]           w_pc;
    logic [2:0]            w_mul_op;
    logic [31:0]           w_alu_result;
    logic [4:0]            w_load_op;
    logic [4:0]            w_dest;
    logic                  w_gr_we;
    logic [EXCEPT_LEN-1:0] w_except_zip;

    logic        w_latch;
    logic        w_ms2ws_go;
    logic        w_capture;
    logic        w_is_load;
    logic [31:0] w_rdata_sel;
    logic [63:0] w_mul_sel;
    logic [31:0] w_load_data;
    logic [31:0] w_mul_data;
    logic [31:0] w_final_result;
    logic [31:0] w_fwd_data;
    logic        w_ms_rf_we;
    logic [3:0]  w_unused_mul_hi;

    assign {w_pc, w_mul_op, w_alu_result, w_load_op, w_dest, w_gr_we, w_except_zip} = r_es2ms_bus;

    assign w_unused_mul_hi = mul_result[67:64];

    assign ms_allowin  = ~r_ms_valid | ws_allowin;
    assign ms2ws_valid = r_ms_valid;
    assign w_latch     = es2ms_valid & ms_allowin;
    assign w_ms2ws_go  = r_ms_valid & ws_allowin;
    // SRAM data and product are only presented in the first MEM cycle
    assign w_capture   = r_ms_valid & r_first & ~ws_allowin;
    assign w_is_load   = |w_load_op;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid     <= 1'b0;
            r_first        <= 1'b0;
            r_res_from_mul <= 1'b0;
        end else begin
            if (wb_ex) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es2ms_valid;
            end
            r_first <= w_latch;
            if (w_latch) begin
                r_res_from_mul <= es_res_from_mul;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_buf_v <= 1'b0;
            r_mul_buf_v   <= 1'b0;
        end else begin
            if (wb_ex | w_ms2ws_go | w_latch) begin
                r_rdata_buf_v <= 1'b0;
            end else if (w_capture & w_is_load) begin
                r_rdata_buf_v <= 1'b1;
            end
            if (wb_ex | w_ms2ws_go | w_latch) begin
                r_mul_buf_v <= 1'b0;
            end else if (w_capture & r_res_from_mul) begin
                r_mul_buf_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_es2ms_bus <= es2ms_bus;
        end
        if (w_capture & w_is_load) begin
            r_rdata_buf <= data_sram_rdata;
        end
        if (w_capture & r_res_from_mul) begin
            r_mul_buf <= mul_result[63:0];
        end
    end

    assign w_rdata_sel = r_rdata_buf_v ? r_rdata_buf : data_sram_rdata;
    assign w_mul_sel   = r_mul_buf_v   ? r_mul_buf   : mul_result[63:0];

    load_extend u_load_extend (
        .i_rdata   (w_rdata_sel),
        .i_addr    (w_alu_result[1:0]),
        .i_load_op (w_load_op),
        .o_result  (w_load_data)
    );

    always_comb begin
        w_mul_data = 32'b0;
        if (w_mul_op[c_MUL_W]) begin
            w_mul_data = w_mul_sel[31:0];
        end else if (w_mul_op[c_MULH_W] | w_mul_op[c_MULH_WU]) begin
            w_mul_data = w_mul_sel[63:32];
        end
    end

    always_comb begin
        w_final_result = w_alu_result;
        if (w_is_load) begin
            w_final_result = w_load_data;
        end else if (r_res_from_mul) begin
            w_final_result = w_mul_data;
        end
    end

    // Exceptions still carry gr_we; write-back is the one that suppresses it
    assign w_ms_rf_we = r_ms_valid & w_gr_we;

`ifdef MS_LOAD_FWD_EN
    assign w_fwd_data  = w_final_result;
    assign ms_ld_block = 1'b0;
`else
    // Keeps the SRAM read data off the decode-stage combinational path
    assign w_fwd_data  = w_is_load ? w_alu_result : w_final_result;
    assign ms_ld_block = r_ms_valid & w_is_load & w_gr_we;
`endif

    assign mem_forward_zip = {w_ms_rf_we, w_dest, w_fwd_data};
    assign ms2ws_bus       = {w_pc, w_final_result, w_gr_we, w_dest, w_except_zip};
    assign ms_ex           = r_ms_valid & w_except_zip[c_EXC_BIT];
    assign ms_csr_re       = r_ms_valid & w_except_zip[c_CSR_RE_BIT];

endmodule

`default_nettype wire
